exe_mul_seq: RTL
================

// Module: exe_mul_seq
// PURPOSE
//  Sequential shift-add multiplier on the consumer side of the ID->EX pipeline register.
//  Takes is_mul, both register-file operands and dest_reg from the ID/EX outputs.
//  Drives stall back to the front end (PC, IF/ID and ID/EX loads) until the product is ready.
//  Hands the low WIDTH bits of the product to EX/MEM for write-back.
// PARAMETERS
//  WIDTH   32  operand/result width (`REGISTER_LEN); must be even
//  DEST_W  4   destination register address width (`REG_ADDRESS_LEN)
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       reset, asynchronous, active-low (0 = reset)
//  start     in   1       ID/EX is_mul_out; a multiply occupies EX this cycle
//  flush     in   1       branch flush; kills any multiply in flight
//  op_a      in   WIDTH   ID/EX reg_file_out1 (Rm)
//  op_b      in   WIDTH   ID/EX reg_file_out2 (Rs)
//  dest_in   in   DEST_W  ID/EX dest_reg_out
//  stall     out  1       freeze front end and ID/EX register
//  done      out  1       one-cycle pulse; result/dest_out/wb_en valid
//  wb_en     out  1       write-back enable for product (== done)
//  result    out  WIDTH   low WIDTH bits of op_a*op_b
//  dest_out  out  DEST_W  destination register of completed multiply
// BEHAVIOUR
//  - Reset (rst=0, any time, async): state=IDLE, cnt=0, acc=0, opa/opb regs=0.
//    Outputs: result=0, dest_out=0, done=0, wb_en=0. stall=0 (combinational, IDLE && start=0).
//  - N = WIDTH iterations (1 multiplier bit per cycle); N = WIDTH/2 when radix-4 enabled.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start=1 && flush=0: latch op_a->mcand, op_b->mplier, dest_in; acc=0, cnt=0; go RUN.
//    start=0 or flush=1: stay IDLE.
//  - RUN: per cycle, if mplier[0] then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
//    All arithmetic mod 2^WIDTH; carries beyond WIDTH dropped.
//    After cnt reaches N-1 iteration: go DONE, result<=acc, dest_out<=dest. start is ignored in RUN.
//  - DONE: done=wb_en=1 for exactly one cycle; go IDLE.
//    start ignored in DONE: the same instruction is still in ID/EX and must not retrigger.
//  - stall = !flush && ((IDLE && start) || RUN); 0 in DONE so the pipeline advances with result.
//  - Latency: start seen in cycle 0 -> stall high cycles 0..N -> done in cycle N+1.
//    N+1 stall cycles total.
//  - flush in RUN: next state IDLE, acc discarded, no done; stall drops same cycle.
//  - flush in DONE: done/wb_en forced 0 that cycle; go IDLE.
//  - flush && start in IDLE: flush wins, no start.
//  - result and dest_out hold their last completed value until the next DONE (or reset).
//  - Signed/unsigned give identical low WIDTH bits; no sign handling needed.
//  - Back-to-back multiplies: second start accepted in the IDLE cycle after DONE.
// CONFIGURATION
//  - MUL_RADIX4_EN defined: two multiplier bits per RUN cycle.
//    acc += (mplier[0]?mcand:0) + (mplier[1]?mcand<<1:0); mcand<<=2; mplier>>=2.
//    N = WIDTH/2: stall N+1 = 17 cycles, done at cycle 17 for WIDTH=32.
//  - MUL_RADIX4_EN undefined: radix-2 as above; N = WIDTH: stall 33 cycles, done at cycle 33.
//  - Results bit-identical in both builds.
// TESTING
//  1. start, op_a=3, op_b=5, dest_in=4 -> stall 1 for cycles 0..32;
//     cycle 33: done=wb_en=1, result=15, dest_out=4.
//  2. op_a=op_b=0xFFFFFFFF -> result=0x00000001. op_a=0x00010000, op_b=0x00010000 -> result=0.
//  3. flush at cycle 10 of RUN -> stall 0 that cycle, IDLE next, no done pulse, result unchanged.
//  4. rst=0 asserted mid-RUN (between clocks) -> outputs 0 immediately.
//     After release, start 7*6 -> result=42 at cycle 33.
//  5. start held high through DONE, then a new multiply 2*9 -> exactly one done per instruction.
//     Second result=18, start accepted in the cycle after DONE.
//  6. Build with MUL_RADIX4_EN: 3*5 -> stall cycles 0..16, done at cycle 17, result=15.
//     Repeat tests 2-5 with N=16.

Source files
------------

// File: rtl/exe_mul_seq.sv
// ---------------------------------------------------------------------------
// exe_mul_seq
// Sequential shift-add multiplier sitting behind the ID/EX pipeline register.
// A multiply seen on `start` is latched, iterated one (radix-2) or two
// (radix-4) multiplier bits per cycle, and the low WIDTH bits of the product
// are handed to EX/MEM with a one-cycle `done`/`wb_en` pulse. While the
// multiply is in flight `stall` freezes the PC, IF/ID and ID/EX registers.
//
// Build option:
//   MUL_RADIX4_EN  defined   -> two multiplier bits per cycle, N = WIDTH/2
//                  undefined -> one multiplier bit per cycle,  N = WIDTH
//   Products are bit-identical in both builds.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   start     in   ID/EX is_mul: a multiply occupies EX this cycle
//   flush     in   branch flush; kills any multiply in flight
//   op_a      in   multiplicand (Rm)
//   op_b      in   multiplier   (Rs)
//   dest_in   in   destination register of the multiply
//   stall     out  freeze front end and ID/EX register
//   done      out  one-cycle pulse; result/dest_out valid
//   wb_en     out  write-back enable for the product (same as done)
//   result    out  low WIDTH bits of op_a*op_b, held until the next completion
//   dest_out  out  destination register of the completed multiply
// ---------------------------------------------------------------------------
module exe_mul_seq #(
   parameter int WIDTH  = 32,
   parameter int DEST_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic [DEST_W-1:0] dest_in,
   output logic              stall,
   output logic              done,
   output logic              wb_en,
   output logic [WIDTH-1:0]  result,
   output logic [DEST_W-1:0] dest_out
);

`ifdef MUL_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int N     = WIDTH / STEP;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [DEST_W-1:0]  dest;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   acc_sum;

   // Partial product for this iteration; carries beyond WIDTH are dropped,
   // which is exactly the mod 2^WIDTH behaviour the write-back needs.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      addend = '0;
`ifdef MUL_RADIX4_EN
      if (mplier[0]) addend = mcand;
      if (mplier[1]) addend = addend + (mcand << 1);
`else
      if (mplier[0]) addend = mcand;
`endif
      acc_sum = acc + addend;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start && !flush) state_next = RUN;
         RUN: begin
            if (flush)             state_next = IDLE;
            else if (cnt == LAST)  state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Low in DONE so the pipeline advances together with the result;
      // start is deliberately ignored there because the same instruction is
      // still sitting in ID/EX.
      stall = !flush && ((state == IDLE && start) || state == RUN);
      done  = (state == DONE) && !flush;
      wb_en = done;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         dest     <= '0;
         result   <= '0;
         dest_out <= '0;
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (start && !flush) begin
                  mcand  <= op_a;
                  mplier <= op_b;
                  dest   <= dest_in;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (!flush) begin
                  acc    <= acc_sum;
                  mcand  <= mcand << STEP;
                  mplier <= mplier >> STEP;
                  cnt    <= cnt + 1'b1;
                  // Capture on the last iteration using the sum that includes
                  // this cycle's partial product.
                  if (cnt == LAST) begin
                     result   <= acc_sum;
                     dest_out <= dest;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
